// File: rtl/my_fog_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : my_fog_pkg
//  Description : Shared types and constants for the feedback loop stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package my_fog_pkg;

    typedef enum logic [1:0] {
        WAIT_STEP = 2'd0,
        WAIT_RATE = 2'd1,
        WAIT_RAMP = 2'd2
    } loop_state_t;

    localparam logic signed [31:0] STEP_MAX = 32'h7FFF_FFFF;
    localparam logic signed [31:0] STEP_MIN = 32'h8000_0000;

endpackage
`default_nettype wire

// File: rtl/my_sat_add32.sv
`default_nettype none
// ============================================================================
//  Module      : my_sat_add32
//  Description : Combinational signed 32+32 saturating adder with overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module my_sat_add32
    import my_fog_pkg::*;
(
    input  logic signed [31:0] i_a,
    input  logic signed [31:0] i_b,
    output logic signed [31:0] o_sum,
    output logic               o_ovf
);

    logic [32:0] w_sum;

    always_comb begin
        w_sum = {i_a[31], i_a} + {i_b[31], i_b};
        o_ovf = (w_sum[32] != w_sum[31]);
        if (o_ovf) begin
            // The extra sign bit holds the true sign of the unclamped result.
            o_sum = w_sum[32] ? STEP_MIN : STEP_MAX;
        end else begin
            o_sum = w_sum[31:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/my_step_ramp_gen.sv
`default_nettype none
// ============================================================================
//  Module      : my_step_ramp_gen
//  Description : Integrates the error into a saturating step accumulator and
//                the step into a wrapping DAC phase ramp, sequenced by syncs.
//  Revision    : 1.0 - initial release
// ============================================================================
module my_step_ramp_gen
    import my_fog_pkg::*;
#(
    parameter int DAC_BIT = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_loop_en,
    input  logic [4:0]          i_gain_sel,
    input  logic signed [31:0]  i_const_step,
    input  logic signed [31:0]  i_err,
    input  logic                i_step_sync,
    input  logic                i_rate_sync,
    input  logic                i_ramp_sync,
    output logic signed [31:0]  o_step,
    output logic signed [31:0]  o_rate,
    output logic                o_rate_valid,
    output logic [DAC_BIT-1:0]  o_ramp,
    output logic                o_ramp_valid,
    output logic                o_sat,
    output logic                o_seq_err,
    output logic [1:0]          o_cstate
);

    loop_state_t        state_q, state_d;
    logic signed [31:0] step_acc_q, step_acc_d;
    logic [31:0]        ramp_acc_q, ramp_acc_d;
    logic signed [31:0] rate_q, rate_d;
    logic               rate_valid_q, rate_valid_d;
    logic               ramp_valid_q, ramp_valid_d;
    logic               sat_q, sat_d;
    logic               seq_err_q, seq_err_d;

    logic signed [31:0] w_err_scaled;
    logic signed [31:0] w_sat_sum;
    logic               w_sat_ovf;
    logic               w_multi;
    logic               w_do_step;
    logic               w_do_rate;
    logic               w_do_ramp;
    logic               w_unexpected;

    assign w_err_scaled = i_err >>> i_gain_sel;

    my_sat_add32 u_sat_add (
        .i_a   (step_acc_q),
        .i_b   (w_err_scaled),
        .o_sum (w_sat_sum),
        .o_ovf (w_sat_ovf)
    );

    always_comb begin
        w_multi = ({1'b0, i_step_sync} + {1'b0, i_rate_sync} + {1'b0, i_ramp_sync}) > 2'd1;
        // A lone step sync in any state resyncs; with company it only counts when expected.
        w_do_step = i_step_sync && ((state_q == WAIT_STEP) || !w_multi);
        w_do_rate = i_rate_sync && (state_q == WAIT_RATE);
        w_do_ramp = i_ramp_sync && (state_q == WAIT_RAMP);
        w_unexpected = (i_step_sync && (state_q != WAIT_STEP)) ||
                       (i_rate_sync && (state_q != WAIT_RATE)) ||
                       (i_ramp_sync && (state_q != WAIT_RAMP));
    end

    always_comb begin
        state_d      = state_q;
        step_acc_d   = step_acc_q;
        ramp_acc_d   = ramp_acc_q;
        rate_d       = rate_q;
        rate_valid_d = 1'b0;
        ramp_valid_d = 1'b0;
        sat_d        = sat_q;
        seq_err_d    = seq_err_q || w_unexpected;

        if (w_do_step) begin
            state_d = WAIT_RATE;
            if (i_loop_en) begin
                step_acc_d = w_sat_sum;
                sat_d      = sat_q || w_sat_ovf;
            end else begin
                step_acc_d = i_const_step;
            end
        end else if (w_do_rate) begin
            state_d      = WAIT_RAMP;
            rate_d       = step_acc_q;
            rate_valid_d = 1'b1;
        end else if (w_do_ramp) begin
            state_d      = WAIT_STEP;
            ramp_acc_d   = ramp_acc_q + step_acc_q;
            ramp_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= WAIT_STEP;
            step_acc_q   <= '0;
            ramp_acc_q   <= '0;
            rate_q       <= '0;
            rate_valid_q <= 1'b0;
            ramp_valid_q <= 1'b0;
            sat_q        <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_acc_q   <= step_acc_d;
            ramp_acc_q   <= ramp_acc_d;
            rate_q       <= rate_d;
            rate_valid_q <= rate_valid_d;
            ramp_valid_q <= ramp_valid_d;
            sat_q        <= sat_d;
            seq_err_q    <= seq_err_d;
        end
    end

    assign o_step       = step_acc_q;
    assign o_rate       = rate_q;
    assign o_rate_valid = rate_valid_q;
    assign o_ramp       = ramp_acc_q[31:32-DAC_BIT];
    assign o_ramp_valid = ramp_valid_q;
    assign o_sat        = sat_q;
    assign o_seq_err    = seq_err_q;
    assign o_cstate     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_my_step_ramp_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_my_step_ramp_gen
//  Description : Directed self-checking bench for my_step_ramp_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_my_step_ramp_gen;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               loop_en = 1'b0;
    logic [4:0]         gain_sel = 5'd0;
    logic signed [31:0] const_step = '0;
    logic signed [31:0] err = '0;
    logic               step_sync = 1'b0;
    logic               rate_sync = 1'b0;
    logic               ramp_sync = 1'b0;

    logic signed [31:0] o_step, o_rate, o_step32, o_rate32;
    logic               o_rate_valid, o_ramp_valid, o_sat, o_seq_err;
    logic               o_rate_valid32, o_ramp_valid32, o_sat32, o_seq_err32;
    logic [15:0]        o_ramp;
    logic [31:0]        o_ramp32;
    logic [1:0]         o_cstate, o_cstate32;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    my_step_ramp_gen #(.DAC_BIT(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_loop_en(loop_en), .i_gain_sel(gain_sel),
        .i_const_step(const_step), .i_err(err), .i_step_sync(step_sync),
        .i_rate_sync(rate_sync), .i_ramp_sync(ramp_sync), .o_step(o_step),
        .o_rate(o_rate), .o_rate_valid(o_rate_valid), .o_ramp(o_ramp),
        .o_ramp_valid(o_ramp_valid), .o_sat(o_sat), .o_seq_err(o_seq_err),
        .o_cstate(o_cstate)
    );

    // Full-width instance exposes the whole ramp accumulator.
    my_step_ramp_gen #(.DAC_BIT(32)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_loop_en(loop_en), .i_gain_sel(gain_sel),
        .i_const_step(const_step), .i_err(err), .i_step_sync(step_sync),
        .i_rate_sync(rate_sync), .i_ramp_sync(ramp_sync), .o_step(o_step32),
        .o_rate(o_rate32), .o_rate_valid(o_rate_valid32), .o_ramp(o_ramp32),
        .o_ramp_valid(o_ramp_valid32), .o_sat(o_sat32), .o_seq_err(o_seq_err32),
        .o_cstate(o_cstate32)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step_sync = 1'b0; rate_sync = 1'b0; ramp_sync = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
    endtask

    // One full step/rate/ramp sequence with the upstream N, N+2, N+3 spacing.
    task automatic seq(input logic signed [31:0] e, input logic [31:0] exp_step);
        err = e; step_sync = 1'b1;
        cyc();
        step_sync = 1'b0;
        chk("seq_step", o_step, exp_step);
        chk("seq_state_rate", o_cstate, 2'd1);
        cyc();
        rate_sync = 1'b1;
        cyc();
        rate_sync = 1'b0;
        chk("seq_rate", o_rate, exp_step);
        chk("seq_rate_valid", o_rate_valid, 1'b1);
        chk("seq_state_ramp", o_cstate, 2'd2);
        ramp_sync = 1'b1;
        cyc();
        ramp_sync = 1'b0;
        chk("seq_rate_valid_drop", o_rate_valid, 1'b0);
        chk("seq_ramp_valid", o_ramp_valid, 1'b1);
        chk("seq_state_step", o_cstate, 2'd0);
        cyc();
        chk("seq_ramp_valid_drop", o_ramp_valid, 1'b0);
    endtask

    initial begin
        do_reset();
        chk("rst_step", o_step, 32'd0);
        chk("rst_rate", o_rate, 32'd0);
        chk("rst_ramp", o_ramp32, 32'd0);
        chk("rst_flags", {o_rate_valid, o_ramp_valid, o_sat, o_seq_err}, 4'b0);
        chk("rst_state", o_cstate, 2'd0);

        // Closed loop, 400 >>> 2 = 100 per step.
        loop_en = 1'b1; gain_sel = 5'd2;
        seq(32'sd400, 32'd100);
        chk("cl_ramp1", o_ramp32, 32'd100);
        chk("cl_ramp1_dac", o_ramp, 16'd0);
        seq(32'sd400, 32'd200);
        chk("cl_ramp2", o_ramp32, 32'd300);
        seq(32'sd400, 32'd300);
        chk("cl_ramp3", o_ramp32, 32'd600);
        chk("cl_flags", {o_sat, o_seq_err}, 2'b00);

        // Negative error with arithmetic shift: -400 >>> 2 = -100.
        seq(-32'sd400, 32'd200);
        chk("cl_ramp4", o_ramp32, 32'd800);

        // Saturation.
        do_reset();
        loop_en = 1'b0; const_step = 32'h7FFF_FF00;
        seq(32'sd0, 32'h7FFF_FF00);
        chk("sat_pre", o_sat, 1'b0);
        loop_en = 1'b1; gain_sel = 5'd0;
        seq(32'sh1000, 32'h7FFF_FFFF);
        chk("sat_set", o_sat, 1'b1);
        seq(-32'sd1, 32'h7FFF_FFFE);
        chk("sat_sticky", o_sat, 1'b1);

        // Ramp wrap through the 16-bit DAC word.
        do_reset();
        loop_en = 1'b0; const_step = 32'h4000_0000;
        seq(32'sd0, 32'h4000_0000); chk("wrap1", o_ramp, 16'h4000);
        seq(32'sd0, 32'h4000_0000); chk("wrap2", o_ramp, 16'h8000);
        seq(32'sd0, 32'h4000_0000); chk("wrap3", o_ramp, 16'hC000);
        seq(32'sd0, 32'h4000_0000); chk("wrap4", o_ramp, 16'h0000);
        seq(32'sd0, 32'h4000_0000); chk("wrap5", o_ramp, 16'h4000);
        chk("wrap_flags", {o_sat, o_seq_err}, 2'b00);

        // Rate sync while waiting for a step is ignored.
        do_reset();
        loop_en = 1'b0; const_step = 32'sd77;
        seq(32'sd0, 32'd77);
        rate_sync = 1'b1;
        cyc();
        rate_sync = 1'b0;
        chk("oos_rate_hold", o_rate, 32'd77);
        chk("oos_rate_valid", o_rate_valid, 1'b0);
        chk("oos_rate_state", o_cstate, 2'd0);
        chk("oos_rate_err", o_seq_err, 1'b1);

        // Step sync while waiting for the ramp resynchronises.
        do_reset();
        const_step = 32'sd5;
        step_sync = 1'b1; cyc(); step_sync = 1'b0;
        cyc();
        rate_sync = 1'b1; cyc(); rate_sync = 1'b0;
        chk("resync_pre_state", o_cstate, 2'd2);
        chk("resync_pre_err", o_seq_err, 1'b0);
        const_step = 32'sd9;
        step_sync = 1'b1; cyc(); step_sync = 1'b0;
        chk("resync_step", o_step, 32'd9);
        chk("resync_state", o_cstate, 2'd1);
        chk("resync_err", o_seq_err, 1'b1);
        chk("resync_ramp", o_ramp32, 32'd0);

        // Step and rate together in WAIT_STEP: only the step is acted on.
        do_reset();
        const_step = 32'sd11;
        step_sync = 1'b1; rate_sync = 1'b1;
        cyc();
        step_sync = 1'b0; rate_sync = 1'b0;
        chk("dual_step", o_step, 32'd11);
        chk("dual_state", o_cstate, 2'd1);
        chk("dual_rate", o_rate, 32'd0);
        chk("dual_rate_valid", o_rate_valid, 1'b0);
        chk("dual_err", o_seq_err, 1'b1);

        // Reset in WAIT_RAMP, then a stray ramp sync.
        do_reset();
        const_step = 32'sd500;
        step_sync = 1'b1; cyc(); step_sync = 1'b0;
        cyc();
        rate_sync = 1'b1; cyc(); rate_sync = 1'b0;
        chk("mid_pre_state", o_cstate, 2'd2);
        chk("mid_pre_step", o_step, 32'd500);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("mid_step", o_step, 32'd0);
        chk("mid_rate", o_rate, 32'd0);
        chk("mid_ramp", o_ramp32, 32'd0);
        chk("mid_flags", {o_rate_valid, o_ramp_valid, o_sat, o_seq_err}, 4'b0);
        chk("mid_state", o_cstate, 2'd0);
        ramp_sync = 1'b1; cyc(); ramp_sync = 1'b0;
        chk("mid_ramp_ignored", o_ramp32, 32'd0);
        chk("mid_ramp_valid", o_ramp_valid, 1'b0);
        chk("mid_ramp_state", o_cstate, 2'd0);
        chk("mid_ramp_err", o_seq_err, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/my_step_ramp_gen.md
# my_step_ramp_gen

Closed-loop feedback stage that sits directly downstream of the error-signal generator. It consumes the demodulated error word and its step/rate/ramp sync pulses. It integrates the error into a step (rate) accumulator and integrates the step into a wrapping phase ramp that drives the feedback DAC. It also publishes the captured rate word for readout.

## Interface
- `DAC_BIT`, 16: width of the ramp word sent to the DAC.
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_loop_en`  in  1  1 = closed loop (integrate error); 0 = open loop (step forced to `i_const_step`).
- `i_gain_sel`  in  5  arithmetic right-shift applied to error (0..31).
- `i_const_step`  in  signed 32  open-loop step value.
- `i_err`  in  signed 32  error word; valid while `i_step_sync`=1.
- `i_step_sync`  in  1  one-cycle pulse: new error available.
- `i_rate_sync`  in  1  one-cycle pulse: capture rate.
- `i_ramp_sync`  in  1  one-cycle pulse: advance ramp.
- `o_step`  out  signed 32  step accumulator.
- `o_rate`  out  signed 32  step captured at last rate sync.
- `o_rate_valid`  out  1  one-cycle pulse with new `o_rate`.
- `o_ramp`  out  `DAC_BIT`  ramp accumulator bits [31:32-DAC_BIT].
- `o_ramp_valid`  out  1  one-cycle pulse with new `o_ramp`.
- `o_sat`  out  1  sticky: step accumulator saturated since reset.
- `o_seq_err`  out  1  sticky: out-of-order sync pulse seen since reset.
- `o_cstate`  out  2  FSM state, debug.

## Operation
- FSM states: `WAIT_STEP`(0), `WAIT_RATE`(1), `WAIT_RAMP`(2). Reset state is `WAIT_STEP`.
- `WAIT_STEP` + `i_step_sync` -> `WAIT_RATE`. Step update on the same edge:
  - loop_en=1: `step_acc <= sat32(step_acc + (i_err >>> i_gain_sel))`. The sum is formed in 33 bits and clamped to 0x7FFFFFFF / 0x80000000; on a clamp, set `o_sat`.
  - loop_en=0: `step_acc <= i_const_step`.
- `WAIT_RATE` + `i_rate_sync` -> `WAIT_RAMP`. `o_rate <= step_acc`, `o_rate_valid <= 1` for one cycle.
- `WAIT_RAMP` + `i_ramp_sync` -> `WAIT_STEP`. `ramp_acc <= ramp_acc + step_acc`, modulo 2^32 (wrap intended, no saturation). `o_ramp_valid <= 1` for one cycle.
- Sync pulses not expected in the current state are ignored (no datapath change) and set `o_seq_err`. Exception: `i_step_sync` in `WAIT_RATE` or `WAIT_RAMP` resynchronises. It is processed as in `WAIT_STEP`, the FSM moves to `WAIT_RATE`, and `o_seq_err` is set.
- Two or more sync inputs high in the same cycle: only the one expected by the current state is acted on. Any other asserted sync sets `o_seq_err`; the resync rule does not apply in this case.
- `i_loop_en` and `i_gain_sel` are sampled only on the step-update edge. Changing them between pulses has no effect until the next step update.
- Reset (i_rst_n=0 at an edge), including mid-sequence, clears all state:
  - `step_acc`, `ramp_acc`, `o_rate`, `o_ramp` = 0.
  - `o_rate_valid`, `o_ramp_valid`, `o_sat`, `o_seq_err` = 0.
  - FSM goes to `WAIT_STEP`.
- The sticky flags are cleared by reset only.

## Timing
- All outputs are registered and update on the edge that samples the sync pulse. `o_step` is the `step_acc` register directly.
- Upstream timing: step sync at cycle N, rate sync at N+2, ramp sync at N+3. Error sampled at N; `o_step` valid at N+1; `o_rate` and `o_rate_valid` at N+3; `o_ramp` and `o_ramp_valid` at N+4.
- Minimum spacing: one cycle between the pulses of a sequence. Back-to-back sequences are supported, e.g. a ramp sync at cycle M followed by a step sync at M+1.
- The step accumulator feeds the ramp with zero extra latency: the ramp uses the step value updated at N.

## Structure
- Shared package `my_fog_pkg`:
  - `loop_state_t` enum (2-bit, values above);
  - constants `STEP_MAX` = 0x7FFFFFFF and `STEP_MIN` = 0x80000000.
- One sub-module, `my_sat_add32`: combinational signed 32+32 saturating adder with an overflow flag. The adder is reusable by other loop stages.

## Test plan
- Closed loop, gain_sel=2: three sequences with err=+400. Required: `o_step` = 100, 200, 300; `o_rate` = 100, 200, 300; ramp word 100, 300, 600; each `o_rate_valid`/`o_ramp_valid` is a single cycle at N+3/N+4.
- Saturation: step preloaded near max via loop_en=0 with const_step=0x7FFFFF00, then loop_en=1, gain_sel=0, err=+0x1000. Required: `o_step` = 0x7FFFFFFF and `o_sat`=1. A following err=-1 gives 0x7FFFFFFE.
- Ramp wrap, DAC_BIT=16: open loop with const_step=0x40000000, five sequences. Required `o_ramp` = 0x4000, 0x8000, 0xC000, 0x0000, 0x4000; no flag set.
- Sequence faults:
  - rate sync while in `WAIT_STEP`: ignored, `o_seq_err`=1, `o_rate` unchanged;
  - step sync while in `WAIT_RAMP`: step updated, state = `WAIT_RATE`;
  - step+rate sync together in `WAIT_STEP`: only the step is acted on, `o_seq_err`=1.
- Reset mid-sequence in `WAIT_RAMP` with step=500: all outputs 0 and state `WAIT_STEP` next cycle. A following ramp sync is ignored and flagged.
